// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator.
// Each accepted instruction has its immediate formed combinationally and
// stored in a 2-entry FIFO, which decouples decode from the consumer.

package definitions_pkg;

  typedef enum logic [2:0] {
    IMM_I_TYPE = 3'd0,
    IMM_STORE  = 3'd1,
    IMM_BRANCH = 3'd2,
    IMM_JAL    = 3'd3,
    IMM_U_TYPE = 3'd4,
    IMM_CSR    = 3'd5,
    IMM_SHAMT  = 3'd6
  } imm_e;

endpackage

module imm_gen_pipe
  import definitions_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  imm_e             in_imm_sel,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  // Opcode bits never contribute to the immediate.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^in_inst[6:0];

  logic [XLEN-1:0]  new_imm;
  logic             new_err;

  logic [XLEN-1:0]  mem_imm_q [2];
  logic [XLEN-1:0]  mem_imm_d [2];
  logic [TAG_W-1:0] mem_tag_q [2];
  logic [TAG_W-1:0] mem_tag_d [2];
  logic             mem_err_q [2];
  logic             mem_err_d [2];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       count_q, count_d;

  logic             do_push;
  logic             do_pop;

  // Form the final immediate and error flag for the incoming instruction.
  always_comb begin
    new_imm = {XLEN{in_inst[31]}};
    new_err = 1'b0;
    case (in_imm_sel)
      IMM_I_TYPE: new_imm[11:0] = in_inst[31:20];
      IMM_STORE:  new_imm[11:0] = {in_inst[31:25], in_inst[11:7]};
      IMM_BRANCH: new_imm[12:0] = {in_inst[31], in_inst[7], in_inst[30:25],
                                   in_inst[11:8], 1'b0};
      IMM_JAL:    new_imm[20:0] = {in_inst[31], in_inst[19:12], in_inst[20],
                                   in_inst[30:21], 1'b0};
      IMM_U_TYPE: new_imm[31:0] = {in_inst[31:12], 12'b0};
      IMM_CSR: begin
        new_imm      = '0;
        new_imm[4:0] = in_inst[19:15];
      end
      IMM_SHAMT: begin
        new_imm = '0;
        if (XLEN == 64) begin
          new_imm[5:0] = in_inst[25:20];
        end else begin
          new_imm[4:0] = in_inst[24:20];
          new_err      = in_inst[25];
        end
      end
      default: begin
        new_imm = '0;
        new_err = 1'b1;
      end
    endcase
  end

  // Handshake: readiness comes only from the registered count, and the
  // head entry is masked to zero whenever nothing valid is presented.
  always_comb begin
    in_ready  = !rst && (count_q != 2'd2);
    out_valid = !rst && (count_q != 2'd0);
    do_push   = in_valid && in_ready;
    do_pop    = out_valid && out_ready;
    out_imm   = out_valid ? mem_imm_q[head_q] : '0;
    out_tag   = out_valid ? mem_tag_q[head_q] : '0;
    out_err   = out_valid ? mem_err_q[head_q] : 1'b0;
  end

  // Next-state for the FIFO storage, pointers and occupancy.
  always_comb begin
    mem_imm_d = mem_imm_q;
    mem_tag_d = mem_tag_q;
    mem_err_d = mem_err_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (do_push) begin
      mem_imm_d[tail_q] = new_imm;
      mem_tag_d[tail_q] = in_tag;
      mem_err_d[tail_q] = new_err;
      tail_d            = ~tail_q;
    end
    if (do_pop) begin
      head_d = ~head_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the FIFO and clears stored entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_imm_q[i] <= '0;
        mem_tag_q[i] <= '0;
        mem_err_q[i] <= 1'b0;
      end
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      mem_imm_q <= mem_imm_d;
      mem_tag_q <= mem_tag_d;
      mem_err_q <= mem_err_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the combinational immediate generator. Accepts one (inst, imm_sel, tag) per cycle over a valid/ready handshake and produces an XLEN-wide sign/zero-extended immediate one cycle later. Adds CSR-zimm and shift-amount modes and an error flag for illegal selects or shamt encodings. A 2-entry output buffer decouples decode from the execute-side consumer, so a stall never drops or reorders items.

Parameters:
XLEN, 32, output width; legal values 32 or 64; any other value fails elaboration.
TAG_W, 4, width of the opaque sideband tag carried alongside each item (ROB/PC index).

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  producer has an item
in_ready  output  1  block can accept an item this cycle
in_imm_sel  input  imm_e  immediate format; imm_e gains IMM_CSR and IMM_SHAMT in definitions_pkg
in_inst  input  32  raw instruction word
in_tag  input  TAG_W  sideband tag, passed through unchanged
out_valid  output  1  out_* fields hold a valid item
out_ready  input  1  consumer accepts the item this cycle
out_imm  output  XLEN  generated immediate
out_tag  output  TAG_W  tag of the item on out_imm
out_err  output  1  item had an illegal select or shamt encoding

Behaviour:
- Reset: synchronous, active-high, on clk. While rst=1: in_ready=0, out_valid=0, out_imm=0, out_tag=0, out_err=0, buffer count=0. First cycle after release: in_ready=1.
- Reset mid-operation discards all buffered items. No item accepted in the rst cycle is kept.
- Push when in_valid && in_ready; pop when out_valid && out_ready. Both can occur in the same cycle.
- Storage: 2-entry FIFO (head, tail, count 0..2). in_ready = (count<2). It depends only on registered count, never combinationally on out_ready.
- out_valid = (count>0). out_* always show the head entry.
- While out_valid && !out_ready, out_imm, out_tag and out_err hold stable.
- Latency: an item pushed at edge N, with the buffer empty, is visible at out_* after edge N, so it is poppable in cycle N+1. Sustained throughput is 1 item/cycle when out_ready=1.
- Count transitions:
  - push only: +1
  - pop only: -1
  - push+pop: unchanged
  - count=2: no push possible, pop only
  - count=0: no pop possible
- Pointers are 1-bit and wrap 1->0. Strict FIFO order.
- Immediate formation happens combinationally before the buffer write; the stored value is final. Let S = inst[31] replicated to XLEN.
  - IMM_I_TYPE: S with [11:0]=inst[31:20]
  - IMM_STORE: S with [11:0]={inst[31:25],inst[11:7]}
  - IMM_BRANCH: S with [12:0]={inst[31],inst[7],inst[30:25],inst[11:8],0}
  - IMM_JAL: S with [20:0]={inst[31],inst[19:12],inst[20],inst[30:21],0}
  - IMM_U_TYPE: S with [31:0]={inst[31:12],12'b0}. On XLEN=64, bits 63:32 are copies of inst[31].
  - IMM_CSR: zero-extended inst[19:15]
  - IMM_SHAMT: XLEN=64 gives zero-extended inst[25:20]. XLEN=32 gives zero-extended inst[24:20], and err=1 if inst[25]=1.
  - Any other select value: imm=0, err=1.
- err applies only to its own item; it does not stall, flush or stick.
- Inputs are ignored when in_valid=0 or in_ready=0. The producer must hold its item until accepted; the bench checks this.

Test Plan:
1. Basic formats, XLEN=32, out_ready=1:
   - I, inst 0xFFF00093 -> out_imm 0xFFFFFFFF, err 0
   - BRANCH, inst 0xFE000EE3 -> 0xFFFFFFFC
   - JAL, inst 0x0080006F -> 0x00000008
   - Each item appears exactly 1 cycle after its push.
2. XLEN=64: U, inst 0x80000037 -> 0xFFFFFFFF80000000. CSR, inst 0x000F8073 -> 0x000000000000001F. SHAMT, inst 0x03F01013 -> 0x3F, err 0.
3. XLEN=32 error cases: SHAMT with inst[25]=1 -> err 1. Illegal select value -> imm 0, err 1. The next item after each has err 0.
4. Backpressure: hold out_ready=0 and push tags 1,2 -> in_ready drops to 0 after the second push, and out_* stay stable on tag 1. Release out_ready -> tags pop in order 1 then 2, and in_ready returns to 1 the cycle after the first pop.
5. Streaming: 100 random items with random out_ready -> scoreboard sees no loss, duplication or reorder, and every push+pop at count=1 leaves count at 1.
6. Mid-stream reset: with count=2, assert rst for one cycle -> out_valid=0, all out_* =0, and in_ready=0 during rst then 1 after. No stale tag ever appears on out_tag.
